prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle `datapath`. It receives the program as a byte stream, packs bytes little-endian into 32-bit words, and writes them into instruction memory through its write port. It holds the core in reset until the last word is written plus a fixed settle time. This replaces hierarchical pokes of instruction memory with a synthesizable load path.

---
 rtl/sc_pkg.sv | 14 +
 rtl/word_assembler.sv | 38 +++
 rtl/prog_loader.sv | 96 +++++++++
 tb/tb_prog_loader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the single-cycle core slice: loader FSM states and
// word/byte geometry used by the program loader and instruction memory.
package sc_pkg;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_ADDR_W     = 8;   // also sizes inst_mem

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2,
        ERROR = 2'd3
    } loader_state_t;
endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; word/word_done are
// combinational so the parent can register the write on the completing edge.
module word_assembler
    import sc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        data,
    input  logic              last,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);
    logic [1:0]        byte_idx;
    logic [WORD_W-1:0] asm_q;

    // Unfilled upper lanes are still zero in asm_q, which gives the padding.
    always_comb begin
        word      = asm_q | (WORD_W'(data) << {byte_idx, 3'b000});
        word_done = accept & ((byte_idx == 2'd3) | last);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            byte_idx <= '0;
            asm_q    <= '0;
        end else if (accept) begin
            if (word_done) begin
                byte_idx <= '0;
                asm_q    <= '0;
            end else begin
                byte_idx <= byte_idx + 2'd1;
                asm_q    <= word;
            end
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot-time loader: streams program bytes into instruction memory, then
// releases the core from reset after a fixed settle time.
module prog_loader
    import sc_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int HW    = $clog2(RESET_HOLD + 1);

    loader_state_t     state, state_n;
    logic [HW-1:0]     hold_cnt;
    logic              accept, restart_ok, wr, full;
    logic [WORD_W-1:0] word;
    logic              word_done;

    assign accept     = in_valid & in_ready & (state == LOAD);
    assign restart_ok = restart & ((state == RUN) | (state == ERROR));
    assign full       = (word_count == (ADDR_W+1)'(DEPTH));
    assign wr         = word_done & ~full;

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clr       (restart_ok),
        .accept    (accept),
        .data      (in_data),
        .last      (in_last),
        .word      (word),
        .word_done (word_done)
    );

    always_comb begin
        state_n = state;
        case (state)
            LOAD: begin
                if (word_done) begin
                    if (full)         state_n = ERROR;
                    else if (in_last) state_n = HOLD;
                end
            end
            HOLD:      if (hold_cnt == HW'(RESET_HOLD - 1)) state_n = RUN;
            RUN, ERROR: if (restart) state_n = LOAD;
            default:   state_n = LOAD;
        endcase
    end

    // Status outputs are registered from the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            hold_cnt   <= '0;
            word_count <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            in_ready   <= 1'b0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
            imem_we  <= wr;
            if (wr) begin
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= word;
            end
            if (restart_ok)
                word_count <= '0;
            else if (wr)
                word_count <= word_count + (ADDR_W+1)'(1);
            in_ready   <= (state_n == LOAD);
            core_reset <= (state_n != RUN);
            done       <= (state_n == RUN);
            error      <= (state_n == ERROR);
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 4-word memory so overflow is reachable.
module tb_prog_loader;
    localparam int ADDR_W = 2;
    localparam int RH     = 4;

    logic              clk = 1'b0;
    logic              reset, in_valid, in_last, restart;
    logic [7:0]        in_data;
    logic              in_ready, imem_we, core_reset, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int snap;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .RESET_HOLD(RH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .restart    (restart),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always @(negedge clk) if (imem_we) wr_cnt++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_restart;
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_wc"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; restart = 1'b0; in_data = '0;
        step(); step();
        chk_reset_vals("por");
        reset = 1'b0;
        step();
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // single word with last on lane 3
        send(8'h13, 0); send(8'h01, 0); send(8'h01, 0); send(8'hFE, 1);
        chk("w1_we", 32'(imem_we), 32'd1);
        chk("w1_addr", 32'(imem_addr), 32'd0);
        chk("w1_data", imem_wdata, 32'hFE010113);
        chk("w1_ready_drop", 32'(in_ready), 32'd0);
        chk("w1_wc", 32'(word_count), 32'd1);
        idle(RH - 1);
        chk("w1_hold_core_reset", 32'(core_reset), 32'd1);
        chk("w1_hold_done", 32'(done), 32'd0);
        idle(1);
        chk("w1_run_core_reset", 32'(core_reset), 32'd0);
        chk("w1_run_done", 32'(done), 32'd1);

        // restart with a byte offered on the same cycle: the byte is dropped
        restart = 1'b1; in_valid = 1'b1; in_data = 8'hAA; in_last = 1'b0;
        step();
        restart = 1'b0;
        chk("rs_core_reset", 32'(core_reset), 32'd1);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd1);
        chk("rs_wc", 32'(word_count), 32'd0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        chk("rs_addr", 32'(imem_addr), 32'd0);
        chk("rs_data", imem_wdata, 32'h44332211);
        idle(RH);
        chk("rs_run", 32'(done), 32'd1);

        // two words with an in_valid gap after the third byte
        pulse_restart();
        send(8'h13, 0); send(8'h01, 0); send(8'h01, 0);
        idle(1);
        chk("gap_ready", 32'(in_ready), 32'd1);
        chk("gap_no_we", 32'(imem_we), 32'd0);
        send(8'hFE, 0);
        chk("g0_we", 32'(imem_we), 32'd1);
        chk("g0_addr", 32'(imem_addr), 32'd0);
        chk("g0_data", imem_wdata, 32'hFE010113);
        chk("g0_ready", 32'(in_ready), 32'd1);
        send(8'h23, 0);
        chk("g_b2b_we_drop", 32'(imem_we), 32'd0);
        send(8'h26, 0); send(8'h81, 0); send(8'h02, 1);
        chk("g1_addr", 32'(imem_addr), 32'd1);
        chk("g1_data", imem_wdata, 32'h02812623);
        chk("g1_wc", 32'(word_count), 32'd2);
        idle(RH);
        chk("g_run", 32'(done), 32'd1);

        // partial word is zero-padded
        pulse_restart();
        send(8'h93, 0); send(8'h07, 0); send(8'h50, 1);
        chk("pad_we", 32'(imem_we), 32'd1);
        chk("pad_addr", 32'(imem_addr), 32'd0);
        chk("pad_data", imem_wdata, 32'h00500793);
        idle(RH);

        // reset after six bytes aborts the load
        pulse_restart();
        for (int i = 0; i < 6; i++) send(8'(8'hC0 + i), 0);
        in_valid = 1'b0;
        idle(1);
        snap = wr_cnt;
        reset = 1'b1;
        step();
        chk_reset_vals("mid");
        reset = 1'b0;
        step();
        chk("mid_ready", 32'(in_ready), 32'd1);
        chk("mid_no_spurious_wr", 32'(wr_cnt), 32'(snap));
        send(8'hA1, 0); send(8'hB2, 0); send(8'hC3, 0); send(8'hD4, 1);
        chk("mid_addr", 32'(imem_addr), 32'd0);
        chk("mid_data", imem_wdata, 32'hD4C3B2A1);
        idle(RH);

        // overflow: 17 bytes into a 4-word memory
        pulse_restart();
        for (int i = 0; i < 16; i++) send(8'(i), 0);
        chk("ov_w3_addr", 32'(imem_addr), 32'd3);
        chk("ov_w3_data", imem_wdata, 32'h0F0E0D0C);
        chk("ov_wc", 32'(word_count), 32'd4);
        send(8'h10, 1);
        chk("ov_no_we", 32'(imem_we), 32'd0);
        chk("ov_error", 32'(error), 32'd1);
        chk("ov_ready", 32'(in_ready), 32'd0);
        idle(RH + 2);
        chk("ov_sticky", 32'(error), 32'd1);
        chk("ov_core_reset", 32'(core_reset), 32'd1);
        pulse_restart();
        chk("ov_rs_error", 32'(error), 32'd0);
        chk("ov_rs_ready", 32'(in_ready), 32'd1);
        chk("ov_rs_wc", 32'(word_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
